// File: rtl/display_pkg.sv
`default_nettype none
// ============================================================================
// Module   : display_pkg
// Brief    : Segment-bus types and hex glyph table for the digit scanner.
// Revision : 1.0
// ============================================================================
package display_pkg;

  localparam int SEG_W = 7;

  typedef logic [SEG_W-1:0] seg_t;

  localparam seg_t SEG_BLANK = '0;

  // Glyphs listed gfedcba, bit0 = segment a.
  localparam seg_t HEX_GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,
    7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C,
    7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage
`default_nettype wire

// File: rtl/hex_to_7seg.sv
`default_nettype none
// ============================================================================
// Module   : hex_to_7seg
// Brief    : Combinational hex nibble to active-high 7-segment glyph.
// Revision : 1.0
// ============================================================================
module hex_to_7seg
  import display_pkg::*;
(
  input  logic [3:0] i_digit,
  output seg_t       o_seg
);

  assign o_seg = HEX_GLYPH[i_digit];

endmodule
`default_nettype wire

// File: rtl/display_mux_driver.sv
`default_nettype none
// ============================================================================
// Module   : display_mux_driver
// Brief    : Time-multiplexed N-digit 7-segment scanner with guard time,
//            frame-coherent loading, leading-zero suppression and blanking.
// Revision : 1.0
// ============================================================================
module display_mux_driver
  import display_pkg::*;
#(
  parameter int N_DIGITS       = 4,
  parameter int REFRESH_DIV    = 27000,
  parameter int GUARD_CYCLES   = 16,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit AN_ACTIVE_LOW  = 1'b1
)(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*N_DIGITS-1:0] value_i,
  input  logic                  load_i,
  input  logic [N_DIGITS-1:0]   dp_i,
  input  logic                  blank_i,
  input  logic                  lz_suppress_i,
  output seg_t                  seg_o,
  output logic                  dp_o,
  output logic [N_DIGITS-1:0]   an_o,
  output logic                  frame_o
);

  localparam int c_PRESC_W = $clog2(REFRESH_DIV);
  localparam int c_IDX_W   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  localparam logic [c_PRESC_W-1:0] c_PRESC_LAST = c_PRESC_W'(REFRESH_DIV - 1);
  localparam logic [c_PRESC_W-1:0] c_GUARD      = c_PRESC_W'(GUARD_CYCLES);
  localparam logic [c_IDX_W-1:0]   c_IDX_LAST   = c_IDX_W'(N_DIGITS - 1);
  localparam logic [N_DIGITS-1:0]  c_AN_ONE     = N_DIGITS'(1);
  localparam logic [N_DIGITS-1:0]  c_AN_OFF     = {N_DIGITS{AN_ACTIVE_LOW}};
  localparam seg_t                 c_SEG_OFF    = {SEG_W{SEG_ACTIVE_LOW}};

  logic [c_PRESC_W-1:0]  r_presc;
  logic [c_IDX_W-1:0]    r_idx;
  logic [4*N_DIGITS-1:0] r_pend_val;
  logic [N_DIGITS-1:0]   r_pend_dp;
  logic                  r_pend_vld;
  logic [4*N_DIGITS-1:0] r_act_val;
  logic [N_DIGITS-1:0]   r_act_dp;

  logic                  w_tick;
  logic                  w_wrap;
  logic [3:0]            w_digits [N_DIGITS];
  logic [N_DIGITS-1:0]   w_zero_above;
  logic [3:0]            w_digit;
  seg_t                  w_glyph;
  logic                  w_guard;
  logic                  w_lz_blank;
  seg_t                  w_seg;
  logic                  w_dp;
  logic [N_DIGITS-1:0]   w_an;

  assign w_tick = (r_presc == c_PRESC_LAST);
  assign w_wrap = w_tick && (r_idx == c_IDX_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
      r_idx   <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
      r_idx   <= (r_idx == c_IDX_LAST) ? '0 : r_idx + 1'b1;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  // Active digits change only at the frame wrap; a load on the wrap tick
  // lands in pending and waits for the following frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend_val <= '0;
      r_pend_dp  <= '0;
      r_pend_vld <= 1'b0;
      r_act_val  <= '0;
      r_act_dp   <= '0;
    end else begin
      if (load_i) begin
        r_pend_val <= value_i;
        r_pend_dp  <= dp_i;
      end
      if (load_i) begin
        r_pend_vld <= 1'b1;
      end else if (w_wrap) begin
        r_pend_vld <= 1'b0;
      end
      if (w_wrap && r_pend_vld) begin
        r_act_val <= r_pend_val;
        r_act_dp  <= r_pend_dp;
      end
    end
  end

  for (genvar k = 0; k < N_DIGITS; k++) begin : g_digit
    assign w_digits[k] = r_act_val[4*k +: 4];
  end

  // w_zero_above[k]: digit k and every digit above it are zero.
  always_comb begin
    w_zero_above = '0;
    w_zero_above[N_DIGITS-1] = (w_digits[N_DIGITS-1] == 4'h0);
    for (int k = N_DIGITS - 2; k >= 0; k--) begin
      w_zero_above[k] = w_zero_above[k+1] && (w_digits[k] == 4'h0);
    end
  end

  assign w_digit    = w_digits[r_idx];
  assign w_guard    = (r_presc < c_GUARD);
  assign w_lz_blank = lz_suppress_i && (r_idx != '0) && w_zero_above[r_idx];

  hex_to_7seg u_hex_to_7seg (
    .i_digit (w_digit),
    .o_seg   (w_glyph)
  );

  assign w_seg = (w_guard || w_lz_blank) ? SEG_BLANK : w_glyph;
  assign w_dp  = !w_guard && r_act_dp[r_idx];
  assign w_an  = (w_guard || blank_i) ? '0 : (c_AN_ONE << r_idx);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_o   <= c_SEG_OFF;
      dp_o    <= SEG_ACTIVE_LOW;
      an_o    <= c_AN_OFF;
      frame_o <= 1'b0;
    end else begin
      seg_o   <= w_seg ^ c_SEG_OFF;
      dp_o    <= w_dp ^ SEG_ACTIVE_LOW;
      an_o    <= w_an ^ c_AN_OFF;
      frame_o <= w_wrap;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_display_mux_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_display_mux_driver
// Brief    : Directed vector bench for display_mux_driver (4 digits, div 8).
// Revision : 1.0
// ============================================================================
module tb_display_mux_driver;
  import display_pkg::*;

  localparam int ND    = 4;
  localparam int RD    = 8;
  localparam int GC    = 2;
  localparam int FRAME = ND * RD;

  localparam logic [3:0] AN_SEL [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] value;
  logic        load;
  logic [3:0]  dp;
  logic        blank;
  logic        lz;

  seg_t        seg,  pseg;
  logic        dpo,  pdp;
  logic [3:0]  an,   pan;
  logic        frame, pframe;

  int e;
  int nvec;
  int nfail;

  typedef struct {
    logic [15:0]     val;
    logic [3:0]      dpv;
    logic            lzv;
    logic [3:0][6:0] seg;
    logic [3:0]      edp;
  } vec_t;

  vec_t vecs [8];

  always #5 clk = ~clk;

  display_mux_driver #(
    .N_DIGITS(ND), .REFRESH_DIV(RD), .GUARD_CYCLES(GC),
    .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b1)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .value_i(value), .load_i(load), .dp_i(dp),
    .blank_i(blank), .lz_suppress_i(lz),
    .seg_o(seg), .dp_o(dpo), .an_o(an), .frame_o(frame)
  );

  display_mux_driver #(
    .N_DIGITS(ND), .REFRESH_DIV(RD), .GUARD_CYCLES(GC),
    .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b0)
  ) u_pol (
    .clk(clk), .rst_n(rst_n), .value_i(value), .load_i(load), .dp_i(dp),
    .blank_i(blank), .lz_suppress_i(lz),
    .seg_o(pseg), .dp_o(pdp), .an_o(pan), .frame_o(pframe)
  );

  task automatic step();
    @(posedge clk);
    e++;
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, e);
    end
  endtask

  // Output after edge e shows slot e-1 of the scan.
  function automatic int dig_of();
    return ((e - 1) % FRAME) / RD;
  endfunction

  function automatic int ph_of();
    return (e - 1) % RD;
  endfunction

  task automatic goto_phase(input int ph);
    do step(); while (e % FRAME != ph);
  endtask

  task automatic load_frame(input logic [15:0] v, input logic [3:0] d, input logic l);
    goto_phase(5);
    value = v; dp = d; lz = l; load = 1'b1;
    step();
    load = 1'b0;
    goto_phase(0);
  endtask

  task automatic check_frame(input logic [3:0][6:0] exs, input logic [3:0] edp, input string tag);
    for (int i = 0; i < FRAME; i++) begin
      int d;
      int p;
      step();
      d = dig_of();
      p = ph_of();
      if (p == 4)
        check($sformatf("%s_d%0d", tag, d), {an, seg, dpo}, {AN_SEL[d], exs[d], edp[d]});
      else if (p == 0)
        check($sformatf("%s_guard%0d", tag, d), {an, seg, dpo}, {4'b1111, 7'h00, 1'b0});
    end
  endtask

  task automatic check_post_reset(input string tag);
    step();
    check({tag, "_e1"}, {an, frame}, {4'b1111, 1'b0});
    step();
    check({tag, "_e2"}, {an, frame}, {4'b1111, 1'b0});
    step();
    check({tag, "_e3"}, {an, seg}, {4'b1110, 7'h3F});
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    int cnt [4];
    int dpcnt;
    logic [3:0] exp_an;

    nvec = 0; nfail = 0; e = 0;
    value = '0; load = 1'b0; dp = '0; blank = 1'b0; lz = 1'b0;
    rst_n = 1'b0;

    vecs[0] = '{16'h12AF, 4'b0000, 1'b0, {7'h06, 7'h5B, 7'h77, 7'h71}, 4'b0000};
    vecs[1] = '{16'h0070, 4'b0000, 1'b1, {7'h00, 7'h00, 7'h07, 7'h3F}, 4'b0000};
    vecs[2] = '{16'h0000, 4'b0000, 1'b1, {7'h00, 7'h00, 7'h00, 7'h3F}, 4'b0000};
    vecs[3] = '{16'h0070, 4'b0000, 1'b0, {7'h3F, 7'h3F, 7'h07, 7'h3F}, 4'b0000};
    vecs[4] = '{16'h8D3C, 4'b0100, 1'b0, {7'h7F, 7'h5E, 7'h4F, 7'h39}, 4'b0100};
    vecs[5] = '{16'h0005, 4'b1000, 1'b1, {7'h00, 7'h00, 7'h00, 7'h6D}, 4'b1000};
    vecs[6] = '{16'h0409, 4'b0000, 1'b1, {7'h00, 7'h66, 7'h3F, 7'h6F}, 4'b0000};
    vecs[7] = '{16'h6EB0, 4'b0000, 1'b1, {7'h7D, 7'h79, 7'h7C, 7'h3F}, 4'b0000};

    repeat (3) @(posedge clk);
    #1;
    check("reset_out", {an, seg, dpo, frame}, {4'b1111, 7'h00, 1'b0, 1'b0});
    check("reset_pol", {pan, pseg, pdp}, {4'b0000, 7'h7F, 1'b1});
    rst_n = 1'b1;
    e = 0;
    check_post_reset("start");

    // Frame pulse position and anode duty over two frames.
    goto_phase(0);
    bad = 0;
    for (int d = 0; d < 4; d++) cnt[d] = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      step();
      if (frame !== (e % FRAME == 0)) bad++;
      for (int d = 0; d < 4; d++) if (i < FRAME && an == AN_SEL[d]) cnt[d]++;
    end
    check("frame_pulse", bad, 0);
    for (int d = 0; d < 4; d++) check($sformatf("an_duty_d%0d", d), cnt[d], 6);

    for (int i = 0; i < 8; i++) begin
      load_frame(vecs[i].val, vecs[i].dpv, vecs[i].lzv);
      check_frame(vecs[i].seg, vecs[i].edp, $sformatf("vec%0d", i));
    end

    // Mid-frame load does not disturb the frame in progress.
    load_frame(16'h1111, 4'b0000, 1'b0);
    goto_phase(13);
    check("coh_d1_before", {an, seg}, {4'b1101, 7'h06});
    value = 16'h2222; load = 1'b1;
    step();
    load = 1'b0;
    while (e % FRAME != 0) begin
      step();
      if (ph_of() == 4) check($sformatf("coh_old_d%0d", dig_of()), seg, 7'h06);
    end
    check_frame({7'h5B, 7'h5B, 7'h5B, 7'h5B}, 4'b0000, "coh_new");

    // Load on the wrap tick is deferred one frame.
    goto_phase(31);
    value = 16'h3333; load = 1'b1;
    step();
    load = 1'b0;
    check_frame({7'h5B, 7'h5B, 7'h5B, 7'h5B}, 4'b0000, "wrapload_old");
    check_frame({7'h4F, 7'h4F, 7'h4F, 7'h4F}, 4'b0000, "wrapload_new");

    // Back-to-back loads: the last one wins.
    goto_phase(10);
    value = 16'h4444; load = 1'b1;
    step();
    value = 16'h5555;
    step();
    load = 1'b0;
    goto_phase(0);
    check_frame({7'h6D, 7'h6D, 7'h6D, 7'h6D}, 4'b0000, "lastwins");

    // Five-cycle blank pulse inside the digit-1 slot.
    load_frame(16'h8888, 4'b0100, 1'b0);
    goto_phase(10);
    blank = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      step();
      if (i <= 5 || ph_of() < GC) exp_an = 4'b1111;
      else exp_an = AN_SEL[dig_of()];
      check($sformatf("blank_i%0d", i), an, exp_an);
      if (i == 5) blank = 1'b0;
    end
    goto_phase(0);
    bad = 0;
    dpcnt = 0;
    for (int i = 0; i < FRAME; i++) begin
      step();
      if (dpo !== (dig_of() == 2 && ph_of() >= GC)) bad++;
      if (dpo === 1'b1) dpcnt++;
    end
    check("dp_frame_bad", bad, 0);
    check("dp_frame_cnt", dpcnt, 6);

    // Inverted polarity instance.
    load_frame(16'h0008, 4'b0000, 1'b0);
    for (int i = 0; i < FRAME; i++) begin
      step();
      if (ph_of() == 4 && dig_of() == 0) check("pol_d0", {pan, pseg, pdp}, {4'b0001, 7'h00, 1'b1});
      if (ph_of() == 4 && dig_of() == 1) check("pol_d1", {pan, pseg, pdp}, {4'b0010, 7'h40, 1'b1});
      if (ph_of() == 0 && dig_of() == 2) check("pol_guard", {pan, pseg, pdp}, {4'b0000, 7'h7F, 1'b1});
    end

    // Asynchronous reset mid-scan with a pending load outstanding.
    goto_phase(13);
    value = 16'h9999; load = 1'b1;
    step();
    load = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_out", {an, seg, dpo, frame}, {4'b1111, 7'h00, 1'b0, 1'b0});
    check("async_rst_pol", {pan, pseg, pdp}, {4'b0000, 7'h7F, 1'b1});
    repeat (2) step();
    rst_n = 1'b1;
    e = 0;
    check_post_reset("rerun");
    goto_phase(0);
    check_frame({7'h3F, 7'h3F, 7'h3F, 7'h3F}, 4'b0000, "rst_cleared");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/display_mux_driver.md
Name: display_mux_driver

Overview:
- Time-multiplexed driver for N common-anode/common-cathode 7-segment digits sharing one segment bus.
- Takes a packed N-digit hex value and scans one digit at a time at a prescaled refresh rate.
- Adds anti-ghosting guard time, leading-zero suppression, global blanking and per-digit decimal points.
- Sits between the Gray-to-binary datapath and the board display pins; it replaces direct per-digit combinational decoding.

Parameters:
- N_DIGITS, 4, number of digits scanned (1..8).
- REFRESH_DIV, 27000, clock cycles each digit is selected (>=2).
- GUARD_CYCLES, 16, cycles at start of each digit slot with all anodes inactive (< REFRESH_DIV).
- SEG_ACTIVE_LOW, 0, 1 inverts seg_o and dp_o (lit = 0).
- AN_ACTIVE_LOW, 1, 1 means the selected anode is driven 0.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- value_i  in  4*N_DIGITS  hex digits; digit k = value_i[4k+3:4k], digit 0 = rightmost
- load_i  in  1  capture value_i and dp_i into pending register
- dp_i  in  N_DIGITS  decimal point per digit
- blank_i  in  1  all anodes inactive while high
- lz_suppress_i  in  1  enable leading-zero suppression
- seg_o  out  7  segments, bit0 = a … bit6 = g
- dp_o  out  1  decimal point of the selected digit
- an_o  out  N_DIGITS  digit enables, one-hot when active
- frame_o  out  1  one-cycle pulse when the scan wraps to digit 0

Behaviour:
- Reset (async assert, sync release) clears:
  - prescaler = 0, digit index = 0;
  - pending and active registers = 0, pending_valid = 0;
  - an_o all inactive, seg_o and dp_o all unlit, frame_o = 0.
- Prescaler: counts 0..REFRESH_DIV-1 and wraps. The cycle at REFRESH_DIV-1 is "tick".
- Digit index: advances on tick and wraps N_DIGITS-1 -> 0. frame_o pulses in the cycle the index becomes 0.
- Load / frame coherency:
  - load_i writes the pending register and sets pending_valid. If load_i is high on multiple cycles, the last one wins.
  - The active register is updated from pending only on the tick that wraps to digit 0; pending_valid clears in the same cycle. A frame never mixes old and new digits.
  - load_i coinciding with the wrap tick: the new value goes to pending and is applied at the next frame.
- Segment encoding: standard hex glyphs 0-9, A, b, C, d, E, F, with bit0 = a. Example: 0 -> 0111111, 1 -> 0000110, 8 -> 1111111, F -> 1110001.
- Leading-zero suppression (lz_suppress_i = 1): digit k blanks when it and every higher digit are 0. Digit 0 never blanks. A blanked digit shows all segments unlit but still carries its dp.
- Output registering: all outputs are registered, so they lag index/prescaler by 1 cycle. Output cycle t reflects index/prescaler state at t-1.
- Guard time: for prescaler values 0..GUARD_CYCLES-1 of each slot, an_o is all inactive and seg_o is unlit.
- blank_i: forces an_o inactive from the next cycle. Scanning continues underneath.
- Polarity parameters apply only at the output stage.
- Reset asserted mid-frame: outputs go to reset values immediately (asynchronously). After release, scanning restarts at digit 0 with an empty active register (shows "0" or all digits 0, depending on lz_suppress_i).

Decomposition:
- Package display_pkg holds:
  - SEG_W = 7;
  - typedef seg_t;
  - constant SEG_BLANK;
  - constant array HEX_GLYPH[16] of seg_t.
- Sub-module hex_to_7seg: purely combinational, 4-bit in -> seg_t using HEX_GLYPH, instantiated once on the selected digit.

Test Plan:
- Reset: hold rst_n = 0 mid-scan -> an_o = 1111, seg_o = 0000000, frame_o = 0, all asynchronously. After release, first selected anode is digit 0 at cycle GUARD_CYCLES+1.
- Scan (N_DIGITS=4, REFRESH_DIV=8, GUARD_CYCLES=2):
  - load 0x12AF -> digit0 shows 1110001, digit1 shows 1110111, digit2 shows 1011011, digit3 shows 0000110;
  - an_o sequence 1110, 1101, 1011, 0111;
  - each anode active 6 of 8 cycles; frame_o every 32 cycles.
- Frame coherency: load 0x1111 then 0x2222 in mid-frame (digit 1 selected) -> rest of frame still shows 1s, and the next frame shows all 2s.
- Leading-zero suppression: load 0x0070 with lz_suppress_i = 1 -> digits 3 and 2 unlit, digit 1 = 0000111, digit 0 = 0111111. Load 0x0000 -> only digit 0 lit (0111111).
- Blank and dp: dp_i = 0100, blank_i pulsed 5 cycles -> an_o = 1111 for exactly those 5 cycles (1-cycle lag). dp_o = 1 only while digit 2 is selected.
- Polarity: SEG_ACTIVE_LOW=1, AN_ACTIVE_LOW=0, value 0x0008 -> digit 0 slot gives seg_o = 0000000 and an_o = 0001.
